// File: rtl/bin_to_bcd_scan.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// time-multiplexed common-anode 7-segment display driver.
module bin_to_bcd_scan #(
   parameter int unsigned BIN_W    = 8,
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [6:0]            segments,
   output logic [DIGITS-1:0]     an
);

   // ceil(BIN_W * log10(2)) in integer arithmetic
   localparam int unsigned MinDigits = (BIN_W * 30103 + 99999) / 100000;
   localparam int unsigned CntW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BitW      = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   if (DIGITS < MinDigits) begin : g_bad_digits
      $error("bin_to_bcd_scan: DIGITS too small for BIN_W");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("bin_to_bcd_scan: SCAN_DIV must be >= 1");
   end

   typedef enum logic [0:0] {StIdle, StShift} state_t;

   state_t                r_state, w_state_nxt;
   logic [BIN_W-1:0]      r_shreg, w_shreg_nxt;
   logic [4*DIGITS-1:0]   r_scratch, w_scratch_nxt;
   logic [BitW-1:0]       r_bitcnt, w_bitcnt_nxt;
   logic [4*DIGITS-1:0]   r_bcd, w_bcd_nxt;
   logic                  r_busy, w_busy_nxt;
   logic                  r_done, w_done_nxt;

   logic [4*DIGITS-1:0]   w_adj;
   logic [4*DIGITS-1:0]   w_scr_shift;
   logic                  w_unused_adj_msb;

   // Add-3 on every digit >= 5, then shift the next binary bit in.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   assign w_scr_shift      = {w_adj[4*DIGITS-2:0], r_shreg[BIN_W-1]};
   assign w_unused_adj_msb = w_adj[4*DIGITS-1];

   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_scratch_nxt = r_scratch;
      w_bitcnt_nxt  = r_bitcnt;
      w_bcd_nxt     = r_bcd;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_shreg_nxt   = bin;
               w_scratch_nxt = '0;
               w_bitcnt_nxt  = '0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = StShift;
            end
         end
         StShift: begin
            w_scratch_nxt = w_scr_shift;
            w_shreg_nxt   = {r_shreg[BIN_W-2:0], 1'b0};
            w_bitcnt_nxt  = r_bitcnt + BitW'(1);
            if (r_bitcnt == BitW'(BIN_W - 1)) begin
               w_bcd_nxt   = w_scr_shift;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_shreg   <= '0;
         r_scratch <= '0;
         r_bitcnt  <= '0;
         r_bcd     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_scratch <= w_scratch_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_bcd     <= w_bcd_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;

   // Display scan
   logic [CntW-1:0]   r_cnt;
   logic [IdxW-1:0]   r_idx;
   logic [6:0]        r_seg;
   logic [DIGITS-1:0] r_an;
   logic              w_wrap;
   logic [3:0]        w_digit;
   logic              w_blank;
   logic [6:0]        w_seg;
   logic [DIGITS-1:0] w_an;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign w_wrap  = (r_cnt == CntW'(SCAN_DIV - 1));
   assign w_digit = r_bcd[4*r_idx +: 4];

   // A digit above the units is blank when it and every higher digit are zero.
   always_comb begin
      w_blank = (BLANK_LZ != 0) && (r_idx != '0);
      for (int j = 0; j < int'(DIGITS); j++) begin
         if ((j >= int'(r_idx)) && (r_bcd[4*j +: 4] != 4'd0)) begin
            w_blank = 1'b0;
         end
      end
   end

   always_comb begin
      w_seg = w_blank ? 7'b1111111 : seg_decode(w_digit);
      w_an  = '1;
      w_an[r_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
         r_seg <= 7'b1111111;
         r_an  <= '1;
      end else begin
         if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IdxW'(DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
         end else begin
            r_cnt <= r_cnt + CntW'(1);
         end
         r_seg <= w_seg;
         r_an  <= w_an;
      end
   end

   assign segments = r_seg;
   assign an       = r_an;

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Directed, table-driven bench for bin_to_bcd_scan: an 8-bit/3-digit instance and
// a 4-bit/2-digit instance sharing clock and reset.
module tb_bin_to_bcd_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start1, busy1, done1;
   logic [7:0]  bin1;
   logic [11:0] bcd1;
   logic [6:0]  seg1;
   logic [2:0]  an1;
   logic        start2, busy2, done2;
   logic [3:0]  bin2;
   logic [7:0]  bcd2;
   logic [6:0]  seg2;
   logic [1:0]  an2;

   bin_to_bcd_scan #(.BIN_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .bin(bin1), .busy(busy1), .done(done1),
      .bcd(bcd1), .segments(seg1), .an(an1)
   );

   bin_to_bcd_scan #(.BIN_W(4), .DIGITS(2), .SCAN_DIV(2), .BLANK_LZ(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2), .busy(busy2), .done(done2),
      .bcd(bcd2), .segments(seg2), .an(an2)
   );

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
   localparam logic [6:0] S5 = 7'b0100100, S7 = 7'b0001111, SB = 7'b1111111;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_done1(output int n, output bit stable, input logic [11:0] prev_bcd);
      stable = 1'b1;
      for (n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done1) break;
         if (bcd1 !== prev_bcd) stable = 1'b0;
      end
   endtask

   task automatic convert1(input logic [7:0] b, input logic [11:0] exp, input string name);
      int n;
      bit stable;
      logic [11:0] prev;
      prev = bcd1;
      start1 = 1'b1;
      bin1   = b;
      @(posedge clk); #1;
      start1 = 1'b0;
      bin1   = ~b;
      chk({name, " busy"}, 32'(busy1), 32'd1);
      wait_done1(n, stable, prev);
      chk({name, " latency"}, n, 8);
      chk({name, " no partial bcd"}, 32'(stable), 32'd1);
      chk({name, " busy at done"}, 32'(busy1), 32'd0);
      chk({name, " bcd"}, 32'(bcd1), 32'(exp));
      @(posedge clk); #1;
      chk({name, " done one cycle"}, 32'(done1), 32'd0);
   endtask

   task automatic scan1(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input string name);
      logic [2:0] prev;
      logic [2:0] ean [3];
      logic [6:0] eseg [3];
      int n;
      ean[0] = 3'b110; ean[1] = 3'b101; ean[2] = 3'b011;
      eseg[0] = s0; eseg[1] = s1; eseg[2] = s2;
      prev = an1;
      for (n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (an1 == 3'b110 && prev != 3'b110) break;
         prev = an1;
      end
      chk({name, " sync"}, 32'(n < 40), 32'd1);
      for (int s = 0; s < 3; s++) begin
         for (int c = 0; c < 4; c++) begin
            if (s != 0 || c != 0) begin
               @(posedge clk); #1;
            end
            chk({name, " an"}, 32'(an1), 32'(ean[s]));
            chk({name, " seg"}, 32'(seg1), 32'(eseg[s]));
         end
      end
      @(posedge clk); #1;
      chk({name, " an wrap"}, 32'(an1), 32'(3'b110));
   endtask

   task automatic convert2(input logic [3:0] b, input logic [7:0] exp, input string name);
      int n;
      start2 = 1'b1;
      bin2   = b;
      @(posedge clk); #1;
      start2 = 1'b0;
      bin2   = ~b;
      for (n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done2) break;
      end
      chk({name, " latency"}, n, 4);
      chk({name, " bcd"}, 32'(bcd2), 32'(exp));
   endtask

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd;
   } vec1_t;

   typedef struct {
      logic [3:0] bin;
      logic [7:0] bcd;
   } vec2_t;

   vec1_t vecs1[8];
   vec2_t vecs2[3];

   initial begin
      int n;
      bit stable;
      bit seen;

      vecs1[0] = '{8'd0,   12'h000};
      vecs1[1] = '{8'd1,   12'h001};
      vecs1[2] = '{8'd9,   12'h009};
      vecs1[3] = '{8'd10,  12'h010};
      vecs1[4] = '{8'd59,  12'h059};
      vecs1[5] = '{8'd128, 12'h128};
      vecs1[6] = '{8'd199, 12'h199};
      vecs1[7] = '{8'd255, 12'h255};
      vecs2[0] = '{4'd9,   8'h09};
      vecs2[1] = '{4'd10,  8'h10};
      vecs2[2] = '{4'd15,  8'h15};

      rst_n  = 1'b0;
      start1 = 1'b0;
      bin1   = '0;
      start2 = 1'b0;
      bin2   = '0;
      #12;
      chk("reset busy", 32'(busy1), 32'd0);
      chk("reset done", 32'(done1), 32'd0);
      chk("reset bcd", 32'(bcd1), 32'd0);
      chk("reset an", 32'(an1), 32'(3'b111));
      chk("reset seg", 32'(seg1), 32'(SB));
      chk("reset an2", 32'(an2), 32'(2'b11));
      @(posedge clk); #1;
      rst_n = 1'b1;

      scan1(S0, SB, SB, "scan zero");

      for (int i = 0; i < 8; i++) begin
         convert1(vecs1[i].bin, vecs1[i].bcd, $sformatf("vec%0d", i));
      end
      scan1(S5, S5, S2, "scan 255");

      convert1(8'd100, 12'h100, "conv 100");
      scan1(S0, S0, S1, "scan 100");

      // Start held high through the conversion: the 7 is only taken on the done cycle.
      start1 = 1'b1;
      bin1   = 8'd99;
      @(posedge clk); #1;
      bin1 = 8'd7;
      wait_done1(n, stable, 12'h100);
      chk("hold first latency", n, 8);
      chk("hold first bcd", 32'(bcd1), 32'h099);
      @(posedge clk); #1;
      chk("hold second accepted", 32'(busy1), 32'd1);
      start1 = 1'b0;
      wait_done1(n, stable, 12'h099);
      chk("hold second latency", n, 8);
      chk("hold second bcd", 32'(bcd1), 32'h007);
      scan1(S7, SB, SB, "scan 7");

      // Reset four cycles into a conversion.
      start1 = 1'b1;
      bin1   = 8'd200;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy1), 32'd0);
      chk("abort done", 32'(done1), 32'd0);
      chk("abort bcd", 32'(bcd1), 32'd0);
      chk("abort an", 32'(an1), 32'(3'b111));
      chk("abort seg", 32'(seg1), 32'(SB));
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done1 || busy1) seen = 1'b1;
      end
      chk("abort no done", 32'(seen), 32'd0);
      convert1(8'd200, 12'h200, "conv 200");

      for (int i = 0; i < 3; i++) begin
         convert2(vecs2[i].bin, vecs2[i].bcd, $sformatf("small%0d", i));
      end
      begin
         logic [1:0] prev2;
         prev2 = an2;
         for (n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (an2 == 2'b10 && prev2 != 2'b10) break;
            prev2 = an2;
         end
         chk("small scan sync", 32'(n < 20), 32'd1);
         for (int c = 0; c < 4; c++) begin
            if (c != 0) begin
               @(posedge clk); #1;
            end
            chk("small scan an", 32'(an2), (c < 2) ? 32'(2'b10) : 32'(2'b01));
            chk("small scan seg", 32'(seg2), (c < 2) ? 32'(S5) : 32'(S1));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_scan.md
Name: bin_to_bcd_scan

Overview:
Sequential, parametrised binary-to-BCD converter with a multiplexed multi-digit 7-segment display driver. It sits between datapath results and the board's common-anode display. Conversion uses shift-and-add-3 (double-dabble), one bit per clock, behind a start/busy/done handshake. The latest completed result is time-multiplexed across DIGITS displays with optional leading-zero blanking.

Parameters:
BIN_W, 8, width of the binary input.
DIGITS, 3, number of BCD digits and display positions. Elaboration fails if DIGITS < ceil(BIN_W*log10(2)).
SCAN_DIV, 50000, clock cycles each digit stays enabled. Must be >= 1.
BLANK_LZ, 1, 1 = blank leading zeros. Digit 0 is never blanked.

Ports:
clk  in  1  system clock; all registers on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request conversion of bin; sampled only in IDLE
bin  in  BIN_W  unsigned binary value; captured on the accepting edge
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when bcd is updated
bcd  out  4*DIGITS  packed BCD result; digit i = bcd[4i+3:4i], digit 0 = units
segments  out  7  active-low {a,b,c,d,e,f,g}, a = bit 6
an  out  DIGITS  active-low digit enables, one-hot-low

Behaviour:
- Reset (async assert, sync deassert by the user): state=IDLE, busy=0, done=0, bcd=0, scan counter=0, digit index=0, an=all ones, segments=7'b1111111.
- FSM states: IDLE and SHIFT.
- IDLE:
  - start=1 at edge k captures bin into the shift register, clears the BCD scratch, sets the bit counter to 0, sets busy=1, and moves to SHIFT.
- SHIFT, edges k+1..k+BIN_W, one iteration per edge:
  - Each scratch digit >=5 gets +3; all additions use 4-bit wrap, which the algorithm never exceeds.
  - Then {scratch, shreg} shifts left by 1, MSB of bin first.
  - At edge k+BIN_W: bcd loads the final scratch, done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency: done is visible BIN_W cycles after the accepting edge.
- bcd changes only at completion; partial results are never visible on bcd or the display.
- start while busy=1 is ignored, with no queuing. bin changes during SHIFT have no effect.
- start=1 in the cycle done=1 (state is IDLE) is accepted. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- Reset mid-conversion aborts it immediately. bcd returns to 0 and no done pulse occurs.
- Scan:
  - The free-running counter counts 0..SCAN_DIV-1. On wrap, the digit index advances: DIGITS-1 wraps to 0.
  - an and segments are registered from the current index and bcd, so they lag the index by one cycle.
  - an[idx]=0, all other an bits=1.
- Decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Codes 10-15 map to 1111111; they are unreachable by design.
- Blanking: when BLANK_LZ=1, digit i>0 outputs 1111111 if it and every higher digit are 0. Its an bit is still driven low.
- Scan runs independently of conversion state.

Test Plan:
- Reset with BIN_W=8, DIGITS=3 -> busy=0, done=0, bcd=12'h000, an=3'b111, segments=7'b1111111. Then release rst_n -> an cycles through 110/101/011.
- start with bin=8'd255 -> busy for 8 cycles; done pulses on the 8th edge after acceptance; bcd=12'h255.
- bin=8'd0, BLANK_LZ=1, SCAN_DIV=4:
  - an=110 -> segments=0000001.
  - an=101 and an=011 -> 1111111.
  - Each an value holds 4 cycles.
- bin=8'd99, then start held high through busy with bin=8'd7 -> only 99 is converted (bcd=12'h099). The second start is ignored until IDLE. Holding start across the done cycle converts 7 -> 12'h007.
- Assert rst_n=0 at 4 cycles into converting 8'd200 -> bcd=0, busy=0, no done. Then convert 8'd200 -> 12'h200.
- BIN_W=4, DIGITS=2, bin=4'd15:
  - Expected: bcd=8'h15.
  - Digit 0 -> segments=0100100.
  - Digit 1 -> segments=1001111.
